fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the 16-bit Mipu core. It owns the program counter and drives the 8-bit address of the combinational instruction ROM (IM). It latches the returned word into the decode-stage instruction register and handles start, stall, taken-branch redirect with flush, and HALT detection. It sits between IM and the decode stage; execute feeds redirects back to it.

Parameters:
ADDR_W, 8, instruction address width (IM depth 256).
DATA_W, 16, instruction width.
RESET_PC, 8'h00, PC value after reset and on restart.
NOP_WORD, 16'h0000, word loaded into the IR on reset and on flush.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  level; begins fetch from IDLE, restarts from HALTED.
stall  in  1  decode/hazard stall; freezes PC and IR.
branch_taken  in  1  execute-stage redirect request.
branch_target  in  ADDR_W  redirect address.
im_addr  out  ADDR_W  address to IM; equals the PC register.
im_data  in  DATA_W  IM output for im_addr (combinational, same cycle).
id_ir  out  DATA_W  registered instruction to decode.
id_pc  out  ADDR_W  address id_ir was fetched from.
id_valid  out  1  id_ir is a real instruction this cycle.
halted  out  1  HALT fetched; fetch stopped.
fetch_cnt  out  16  count of instructions issued (id_valid rising edges of issue), saturates at 16'hFFFF.

Behaviour:
- Reset (reset==0, asynchronous): state=IDLE, pc=RESET_PC, id_ir=NOP_WORD, id_pc=0, id_valid=0, halted=0, fetch_cnt=0.
- im_addr = pc at all times, with no added latency. An IM word is captured the same cycle it is addressed, so 1-cycle fetch latency to id_ir.
- FSM states: IDLE, RUN, HALTED. Use a 2-bit encoding.
- IDLE: PC and IR are held and id_valid=0. start=1 moves to RUN on the next edge; the first capture happens in the first RUN cycle.
- RUN, priority is branch_taken > stall > normal:
  - branch_taken=1: pc<=branch_target, id_ir<=NOP_WORD, id_valid<=0 (one bubble). This applies even if stall=1 in the same cycle.
  - stall=1, no branch: pc, id_ir, id_pc, id_valid and fetch_cnt all hold.
  - Normal: id_ir<=im_data, id_pc<=pc, id_valid<=1, fetch_cnt++ (saturating), pc<=pc+1 with modulo-256 wrap (8'hFF -> 8'h00).
  - Normal capture with im_data[15:11]==`HALT: the word is issued (id_valid=1 for that one cycle), pc is NOT incremented, and state moves to HALTED with halted<=1 on the same edge.
- HALTED: id_valid<=0 on the first HALTED edge and stays 0. id_ir keeps the HALT word. branch_taken and stall are ignored.
  - start=1 in HALTED: pc<=RESET_PC, halted<=0, id_ir<=NOP_WORD, state<=RUN. fetch_cnt is not cleared.
- start is ignored in RUN.
- Reset asserted mid-operation aborts immediately to reset values. No partial state survives.
- A branch_taken in IDLE is ignored.
- A redirect to the current pc is legal and behaves as a normal redirect (one bubble).

Decomposition:
- Opcode constants (`HALT=5'b00001, `LOAD, `JUMP, …) and register codes come from the shared define.v. Do not duplicate them locally.
- FSM state encodings (ST_IDLE, ST_RUN, ST_HALTED) and the opcode field slice [15:11] go into define.v alongside them.
- No sub-module: the PC increment/redirect mux and the saturating counter are small enough to stay inline.

Test Plan:
- Reset then start=1 with the GCM/LCM program in IM: the first RUN edge gives id_ir={`LOAD,gr1,0,gr0,4'b0001}, id_pc=0, id_valid=1; the next edge gives id_pc=1, {`LOAD,gr2,…}; fetch_cnt=2.
- stall=1 for 3 cycles at pc=3: im_addr stays 3, id_ir/id_pc stay at addr 2's word, fetch_cnt unchanged. On release, addr 3's word is captured.
- branch_taken=1, branch_target=8'h09 with stall=1 simultaneously: next edge gives pc=9, id_ir=16'h0000, id_valid=0; the following edge gives id_ir={`STORE,gr2,0,gr0,4'b0011}, id_pc=9.
- Run to addr 23 (HALT): id_valid=1 with the HALT word for one cycle, then halted=1, id_valid=0, im_addr frozen at 23, and a branch is ignored. start=1 then gives pc=0, halted=0, and fetch resumes.
- IM filled with non-HALT words and jump-free run from pc=8'hFE: id_pc sequence FE, FF, 00, 01 (wrap). fetch_cnt preset near saturation holds at 16'hFFFF.
- Assert reset for 1 cycle mid-RUN at pc=0x0C: outputs return asynchronously to reset values and state=IDLE; no fetch until start.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared Mipu constants: opcode field slice, opcodes, register codes and the
// fetch FSM state encodings. Imported by every file that decodes an opcode.
package fetch_ctrl_pkg;

  // Opcode field position inside a 16-bit instruction word
  localparam int unsigned OPC_MSB = 15;
  localparam int unsigned OPC_LSB = 11;
  localparam int unsigned OPC_W   = OPC_MSB - OPC_LSB + 1;

  // Opcodes
  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;

  // General-register codes
  localparam logic [2:0] GR0 = 3'd0;
  localparam logic [2:0] GR1 = 3'd1;
  localparam logic [2:0] GR2 = 3'd2;
  localparam logic [2:0] GR3 = 3'd3;
  localparam logic [2:0] GR4 = 3'd4;
  localparam logic [2:0] GR5 = 3'd5;
  localparam logic [2:0] GR6 = 3'd6;
  localparam logic [2:0] GR7 = 3'd7;

  // Fetch FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RUN    = 2'b01;
  localparam logic [1:0] ST_HALTED = 2'b10;

  // True when an opcode field names HALT
  function automatic logic is_halt(input logic [OPC_W-1:0] opc);
    return opc == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the 16-bit Mipu core.
// Owns the PC, addresses the combinational instruction ROM and registers the
// returned word into the decode-stage IR. Handles start/restart, stall,
// taken-branch redirect with a one-cycle bubble, and HALT detection.
// Ports:
//   clock, reset        : clock (rising edge), async active-low reset
//   start               : begin fetch from IDLE / restart from HALTED
//   stall               : freeze PC and IR
//   branch_taken/target : execute-stage redirect
//   im_addr / im_data   : IM address (the PC register) and same-cycle word
//   id_ir/id_pc/id_valid: registered instruction, its address, valid flag
//   halted              : HALT fetched, fetch stopped
//   fetch_cnt           : saturating count of issued instructions
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = 8'h00,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [DATA_W-1:0] im_data,
  output logic [DATA_W-1:0] id_ir,
  output logic [ADDR_W-1:0] id_pc,
  output logic              id_valid,
  output logic              halted,
  output logic [15:0]       fetch_cnt
);

  localparam int unsigned CNT_W = 16;

  logic [1:0]        state_q,     state_d;
  logic [ADDR_W-1:0] pc_q,        pc_d;
  logic [DATA_W-1:0] id_ir_q,     id_ir_d;
  logic [ADDR_W-1:0] id_pc_q,     id_pc_d;
  logic              id_valid_q,  id_valid_d;
  logic              halted_q,    halted_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;

  // Next-state and datapath
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    id_ir_d     = id_ir_q;
    id_pc_d     = id_pc_q;
    id_valid_d  = id_valid_q;
    halted_d    = halted_q;
    fetch_cnt_d = fetch_cnt_q;

    case (state_q)
      ST_IDLE: begin
        id_valid_d = 1'b0;
        if (start) state_d = ST_RUN;
      end

      ST_RUN: begin
        if (branch_taken) begin
          // Redirect wins over stall; the IR slot becomes a bubble
          pc_d       = branch_target;
          id_ir_d    = NOP_WORD;
          id_valid_d = 1'b0;
        end else if (!stall) begin
          id_ir_d     = im_data;
          id_pc_d     = pc_q;
          id_valid_d  = 1'b1;
          fetch_cnt_d = (fetch_cnt_q == {CNT_W{1'b1}}) ? fetch_cnt_q
                                                       : fetch_cnt_q + CNT_W'(1);
          // HALT is issued once, PC parks on it
          if (is_halt(im_data[OPC_MSB:OPC_LSB])) begin
            state_d  = ST_HALTED;
            halted_d = 1'b1;
          end else begin
            pc_d = pc_q + ADDR_W'(1);
          end
        end
      end

      ST_HALTED: begin
        id_valid_d = 1'b0;
        if (start) begin
          pc_d     = RESET_PC;
          id_ir_d  = NOP_WORD;
          halted_d = 1'b0;
          state_d  = ST_RUN;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      id_ir_q     <= NOP_WORD;
      id_pc_q     <= '0;
      id_valid_q  <= 1'b0;
      halted_q    <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      id_ir_q     <= id_ir_d;
      id_pc_q     <= id_pc_d;
      id_valid_q  <= id_valid_d;
      halted_q    <= halted_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  assign im_addr   = pc_q;
  assign id_ir     = id_ir_q;
  assign id_pc     = id_pc_q;
  assign id_valid  = id_valid_q;
  assign halted    = halted_q;
  assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a behavioural combinational IM.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [7:0]  branch_target = 8'h00;
  logic [7:0]  im_addr;
  logic [15:0] im_data;
  logic [15:0] id_ir;
  logic [7:0]  id_pc;
  logic        id_valid;
  logic        halted;
  logic [15:0] fetch_cnt;

  logic [15:0] rom [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  assign im_data = rom[im_addr];

  fetch_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .im_addr      (im_addr),
    .im_data      (im_data),
    .id_ir        (id_ir),
    .id_pc        (id_pc),
    .id_valid     (id_valid),
    .halted       (halted),
    .fetch_cnt    (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  localparam logic [15:0] W_LD1   = {OP_LOAD, GR1, 1'b0, GR0, 4'b0001};
  localparam logic [15:0] W_LD2   = {OP_LOAD, GR2, 1'b0, GR0, 4'b0010};
  localparam logic [15:0] W_ADD   = {OP_ADD, GR3, 1'b0, GR1, 1'b0, GR2};
  localparam logic [15:0] W_SUB   = {OP_SUB, GR4, 1'b0, GR1, 1'b0, GR2};
  localparam logic [15:0] W_ST9   = {OP_STORE, GR2, 1'b0, GR0, 4'b0011};
  localparam logic [15:0] W_HALT  = {OP_HALT, 11'd0};

  int k;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {OP_ADDI, GR4, 8'(i)};
    rom[0]  = W_LD1;
    rom[1]  = W_LD2;
    rom[2]  = W_ADD;
    rom[3]  = W_SUB;
    rom[9]  = W_ST9;
    rom[23] = W_HALT;

    // Reset values
    #12;
    check("rst_im_addr", 32'(im_addr), 32'h00);
    check("rst_id_ir", 32'(id_ir), 32'h0000);
    check("rst_id_pc", 32'(id_pc), 32'h00);
    check("rst_valid", 32'(id_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_cnt", 32'(fetch_cnt), 32'd0);
    reset = 1'b1;

    // IDLE ignores branch
    branch_taken = 1'b1; branch_target = 8'h05;
    tick();
    check("idle_br_addr", 32'(im_addr), 32'h00);
    check("idle_valid", 32'(id_valid), 32'd0);
    branch_taken = 1'b0;

    // Start: first RUN edge captures addr 0
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_valid0", 32'(id_valid), 32'd0);
    tick();
    check("f0_ir", 32'(id_ir), 32'(W_LD1));
    check("f0_pc", 32'(id_pc), 32'h00);
    check("f0_valid", 32'(id_valid), 32'd1);
    check("f0_addr", 32'(im_addr), 32'h01);
    tick();
    check("f1_ir", 32'(id_ir), 32'(W_LD2));
    check("f1_pc", 32'(id_pc), 32'h01);
    check("f1_cnt", 32'(fetch_cnt), 32'd2);
    tick();
    check("f2_addr", 32'(im_addr), 32'h03);

    // Stall 3 cycles at pc=3
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", 32'(im_addr), 32'h03);
      check("stall_ir", 32'(id_ir), 32'(W_ADD));
      check("stall_pc", 32'(id_pc), 32'h02);
      check("stall_cnt", 32'(fetch_cnt), 32'd3);
      check("stall_valid", 32'(id_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
    check("unstall_ir", 32'(id_ir), 32'(W_SUB));
    check("unstall_pc", 32'(id_pc), 32'h03);
    check("unstall_cnt", 32'(fetch_cnt), 32'd4);

    // Branch with simultaneous stall
    branch_taken = 1'b1; branch_target = 8'h09; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("br_addr", 32'(im_addr), 32'h09);
    check("br_ir", 32'(id_ir), 32'h0000);
    check("br_valid", 32'(id_valid), 32'd0);
    check("br_cnt", 32'(fetch_cnt), 32'd4);
    tick();
    check("br9_ir", 32'(id_ir), 32'(W_ST9));
    check("br9_pc", 32'(id_pc), 32'h09);
    check("br9_cnt", 32'(fetch_cnt), 32'd5);

    // Redirect to current pc (10)
    branch_taken = 1'b1; branch_target = 8'h0A;
    tick();
    branch_taken = 1'b0;
    check("self_addr", 32'(im_addr), 32'h0A);
    check("self_valid", 32'(id_valid), 32'd0);
    tick();
    check("self_pc", 32'(id_pc), 32'h0A);
    check("self_cnt", 32'(fetch_cnt), 32'd6);

    // Run to HALT at 23
    k = 0;
    while (!(id_valid && id_pc == 8'd23) && k < 50) begin
      tick();
      k++;
    end
    check("halt_pc", 32'(id_pc), 32'd23);
    check("halt_ir", 32'(id_ir), 32'(W_HALT));
    check("halt_valid", 32'(id_valid), 32'd1);
    check("halt_flag", 32'(halted), 32'd1);
    check("halt_addr", 32'(im_addr), 32'd23);
    check("halt_cnt", 32'(fetch_cnt), 32'd19);
    branch_taken = 1'b1; branch_target = 8'h05; stall = 1'b1;
    tick();
    branch_taken = 1'b0; stall = 1'b0;
    check("hd_valid", 32'(id_valid), 32'd0);
    check("hd_halted", 32'(halted), 32'd1);
    check("hd_addr", 32'(im_addr), 32'd23);
    check("hd_ir", 32'(id_ir), 32'(W_HALT));
    check("hd_cnt", 32'(fetch_cnt), 32'd19);

    // Restart
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rs_addr", 32'(im_addr), 32'h00);
    check("rs_halted", 32'(halted), 32'd0);
    check("rs_ir", 32'(id_ir), 32'h0000);
    check("rs_valid", 32'(id_valid), 32'd0);
    tick();
    check("rs_f_ir", 32'(id_ir), 32'(W_LD1));
    check("rs_f_valid", 32'(id_valid), 32'd1);
    check("rs_f_cnt", 32'(fetch_cnt), 32'd20);

    // Wrap FE, FF, 00, 01
    branch_taken = 1'b1; branch_target = 8'hFE;
    tick();
    branch_taken = 1'b0;
    tick(); check("wrap_fe", 32'(id_pc), 32'hFE);
    tick(); check("wrap_ff", 32'(id_pc), 32'hFF);
    check("wrap_addr", 32'(im_addr), 32'h00);
    tick(); check("wrap_00", 32'(id_pc), 32'h00);
    tick(); check("wrap_01", 32'(id_pc), 32'h01);
    check("wrap_cnt", 32'(fetch_cnt), 32'd24);

    // Async reset mid-RUN at pc 0x0C
    branch_taken = 1'b1; branch_target = 8'h0C;
    tick();
    branch_taken = 1'b0;
    check("pre_rst_addr", 32'(im_addr), 32'h0C);
    #3 reset = 1'b0;
    #1;
    check("ar_addr", 32'(im_addr), 32'h00);
    check("ar_ir", 32'(id_ir), 32'h0000);
    check("ar_pc", 32'(id_pc), 32'h00);
    check("ar_valid", 32'(id_valid), 32'd0);
    check("ar_cnt", 32'(fetch_cnt), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    tick();
    check("ar_idle_addr", 32'(im_addr), 32'h00);
    check("ar_idle_valid", 32'(id_valid), 32'd0);

    // Counter saturation on a HALT-free IM
    rom[23] = {OP_ADDI, GR5, 8'd23};
    start = 1'b1;
    tick();
    start = 1'b0;
    k = 0;
    while (fetch_cnt != 16'hFFFE && k < 70000) begin
      tick();
      k++;
    end
    check("sat_fffe", 32'(fetch_cnt), 32'hFFFE);
    tick();
    check("sat_ffff", 32'(fetch_cnt), 32'hFFFF);
    tick();
    check("sat_hold", 32'(fetch_cnt), 32'hFFFF);
    check("sat_valid", 32'(id_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
